// File: rtl/mux_control_unit.sv
// Purpose: registered datapath mux selects for an in-place radix-2 FFT memory controller.
// Latency: m0_s/m1_s/m2_s one cycle after the sampled inputs; m3_s two cycles.
// Backpressure: none; selects follow the inputs every cycle unconditionally.
module mux_control_unit #(
  parameter int NUMSTAGES = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ld_data,
  input  logic [NUMSTAGES-3:0] counter_r,
  input  logic [2:0]           stage_num_r,
  output logic                 m0_s,
  output logic [1:0]           m1_s,
  output logic                 m2_s,
  output logic                 m3_s
);

  // Stage index of the unload phase, and the first stage whose pair spacing
  // no longer crosses banks (bank swap disabled from here on).
  localparam logic [2:0] LP_UNLOAD_STAGE = 3'(NUMSTAGES);
  localparam logic [2:0] LP_NOSWAP_STAGE = 3'(NUMSTAGES - 2);

  logic       w_m1;
  logic [1:0] w_m1_sel;
  logic       w_m2_sel;

  logic       r_m0;
  logic [1:0] r_m1;
  logic       r_m2;
  logic       r_m3;

  // Address mode: load has priority, then compute, unload, and idle for anything beyond.
  always_comb begin
    w_m1_sel = 2'b11;
    if (ld_data) begin
      w_m1_sel = 2'b00;
    end else if (stage_num_r < LP_UNLOAD_STAGE) begin
      w_m1_sel = 2'b01;
    end else if (stage_num_r == LP_UNLOAD_STAGE) begin
      w_m1_sel = 2'b10;
    end
  end

  // Bank swap: stage s picks counter bit NUMSTAGES-3-s, so earlier stages toggle slower.
  always_comb begin
    w_m2_sel = 1'b0;
    if (!ld_data && (stage_num_r < LP_NOSWAP_STAGE)) begin
      for (int s = 0; s < NUMSTAGES - 2; s++) begin
        if (stage_num_r == 3'(s)) begin
          w_m2_sel = counter_r[NUMSTAGES-3-s];
        end
      end
    end
  end

  assign w_m1 = 1'b0;

  // Output registers; m3 is m2 delayed once more to line up with the butterfly write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m0 <= 1'b0;
      r_m1 <= 2'b00;
      r_m2 <= 1'b0;
      r_m3 <= 1'b0;
    end else begin
      r_m0 <= ld_data;
      r_m1 <= w_m1_sel | {1'b0, w_m1};
      r_m2 <= w_m2_sel;
      r_m3 <= r_m2;
    end
  end

  assign m0_s = r_m0;
  assign m1_s = r_m1;
  assign m2_s = r_m2;
  assign m3_s = r_m3;

endmodule

// File: tb/tb_mux_control_unit.sv
// Purpose: self-checking bench for mux_control_unit against a behavioural model.
// Latency: checks outputs #1 after each rising edge, m3 against the model two cycles back.
// Backpressure: not applicable; inputs change every cycle.
module tb_mux_control_unit;

  localparam int N = 5;

  logic         clk;
  logic         rst;
  logic         ld_data;
  logic [N-3:0] counter_r;
  logic [2:0]   stage_num_r;
  logic         m0_s;
  logic [1:0]   m1_s;
  logic         m2_s;
  logic         m3_s;

  int tests;
  int fails;
  int prev_m2;

  mux_control_unit #(.NUMSTAGES(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_data     (ld_data),
    .counter_r   (counter_r),
    .stage_num_r (stage_num_r),
    .m0_s        (m0_s),
    .m1_s        (m1_s),
    .m2_s        (m2_s),
    .m3_s        (m3_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: address mode from the phase ordering load > compute > unload > idle.
  function automatic int ref_m1(input int ld, input int stg);
    if (ld != 0) return 0;
    if (stg < N) return 1;
    if (stg == N) return 2;
    return 3;
  endfunction

  // Reference: butterfly span for stage s is 2^(N-1-s) samples, i.e. the bank swap
  // follows counter bit N-3-s; no swap during load or in the last two stages.
  function automatic int ref_m2(input int ld, input int stg, input int cnt);
    if (ld != 0) return 0;
    if (stg >= N - 2) return 0;
    return (cnt / (1 << (N - 3 - stg))) % 2;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Apply one set of inputs, clock it in and compare against the model.
  task automatic step(input string tag, input int ld, input int stg, input int cnt);
    int e2;
    ld_data     = ld[0];
    stage_num_r = stg[2:0];
    counter_r   = cnt[N-3:0];
    @(posedge clk);
    #1;
    e2 = ref_m2(ld, stg, cnt);
    check({tag, ".m0"}, int'(m0_s), ld);
    check({tag, ".m1"}, int'(m1_s), ref_m1(ld, stg));
    check({tag, ".m2"}, int'(m2_s), e2);
    check({tag, ".m3"}, int'(m3_s), prev_m2);
    prev_m2 = e2;
  endtask

  // Assert reset off-edge, confirm outputs clear without a clock, then release.
  task automatic do_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    check({tag, ".rst_m0"}, int'(m0_s), 0);
    check({tag, ".rst_m1"}, int'(m1_s), 0);
    check({tag, ".rst_m2"}, int'(m2_s), 0);
    check({tag, ".rst_m3"}, int'(m3_s), 0);
    @(posedge clk);
    #1;
    check({tag, ".rst_hold_m1"}, int'(m1_s), 0);
    rst = 1'b0;
    prev_m2 = 0;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    prev_m2     = 0;
    rst         = 1'b0;
    ld_data     = 1'b0;
    stage_num_r = 3'd6;
    counter_r   = '1;

    // Reset with arbitrary inputs, then a load cycle after release.
    @(posedge clk);
    #1;
    stage_num_r = 3'd1;
    counter_r   = 3'b111;
    do_reset("init");
    step("rel_load", 1, 1, 7);

    // Stage 0 and stage 2 sweeps.
    for (int c = 0; c < 8; c++) step("stg0", 0, 0, c);
    for (int c = 0; c < 8; c++) step("stg2", 0, 2, c);
    // Stage 1 for good measure.
    for (int c = 0; c < 8; c++) step("stg1", 0, 1, c);

    // Stages 3 and 4: never swap.
    for (int k = 0; k < 6; k++) step("stg3", 0, 3, $urandom_range(0, 7));
    for (int k = 0; k < 6; k++) step("stg4", 0, 4, $urandom_range(0, 7));

    // Mode transitions, out-of-range stages, load overriding a swapping stage.
    step("unload", 0, 5, 3);
    step("idle6", 0, 6, 5);
    step("idle7", 0, 7, 7);
    step("ld_stg1", 1, 1, 2);
    step("ld_stg0", 1, 0, 7);
    step("stg0_hi", 0, 0, 4);

    // Mid-stage reset clears everything; no context retained.
    do_reset("mid");
    step("post_mid", 0, 0, 6);

    // Full run: load phase then stages 0..5 with counter wrapping at each increment.
    do_reset("full");
    for (int k = 0; k < 4; k++) step("full_ld", 1, 0, k);
    for (int s = 0; s <= N; s++)
      for (int c = 0; c < 8; c++) step("full", 0, s, c);

    // Random soak with occasional resets.
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) do_reset("rnd");
      step("rnd", ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 7), $urandom_range(0, 7));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
